fp16_vec_accum: RTL and testbench
=================================

Name: fp16_vec_accum

Overview:
- Sequential FP16 vector-reduction controller that drives an external two-stage pipelined FP16 adder and consumes its results.
- Sums a stream of `len` FP16 elements into one FP16 result.
- Hides the adder's 2-cycle latency by keeping two interleaved partial sums, then merges them.
- Sits between the PE operand stream and the result writeback path.

Parameters:
LEN_W, 16, width of the element-count input `len`

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high; the attached adder shares the same rst
start  in  1  begin a reduction; sampled in IDLE only
len  in  LEN_W  element count, latched on accepted start
in_valid  in  1  input element valid
in_data  in  16  FP16 element
in_ready  out  1  element accepted when in_valid && in_ready
add_a  out  16  adder operand A
add_b  out  16  adder operand B
add_sum  in  16  adder result; reflects add_a/add_b presented exactly 2 cycles earlier
out_valid  out  1  result valid
out_data  out  16  FP16 reduction result
out_ready  in  1  result consumed when out_valid && out_ready
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: out_valid=0, out_data=16'h0000, in_ready=0, busy=0, add_a=add_b=16'h0000, state=IDLE, counters/flags cleared.
- Reset mid-operation aborts immediately; there is no partial output. In-flight adder results after reset are ignored because the issue-tracking shift register is cleared.
- Internal state:
  - Park registers p0 and p1 with valid bits.
  - 2-bit issue shift register iss[1:0]; iss[1]=1 means add_sum is a returning partial this cycle (ret).
  - Accepted-element counter cnt (LEN_W bits).
  - Latched len_q.
- Invariant: exactly two partial sums exist during RUN/DRAIN; each is either parked or in flight.
- IDLE:
  - start=1 → latch len_q=len, cnt=0, p0=p1=16'h0000 both valid, go RUN.
  - If len=0, go directly to DONE with out_data=16'h0000.
- RUN:
  - in_ready = (cnt<len_q) && (ret || any park valid).
  - On accept, if ret: issue add_a=add_sum, add_b=in_data. The returning partial has priority for the input.
  - On accept, else: issue add_a=lowest valid park (p0 before p1), add_b=in_data, and clear that park's valid bit.
  - ret with no accept this cycle → add_sum is written into a free park register. One is always free by the invariant.
  - If a returning partial is consumed this cycle and the other partial is parked, that park is untouched.
  - iss shifts each cycle: iss[0] = issue this cycle.
  - cnt increments per accept. When cnt reaches len_q, go DRAIN; in_ready=0 from then on.
- DRAIN:
  - Returning partials are parked.
  - When p0 and p1 are both valid and iss=0, go MERGE.
- MERGE:
  - Issue add_a=p0, add_b=p1 for one cycle.
  - Wait 2 cycles; on the return cycle capture add_sum into out_data.
  - Next state is DONE.
- DONE:
  - out_valid=1; out_data held stable until out_ready=1.
  - On handshake: out_valid drops next cycle, go IDLE.
- add_a/add_b = 16'h0000 on non-issue cycles. A zero operand never alters the sum, because the adder bypasses zero operands.
- start is ignored outside IDLE. in_data arriving while in_ready=0 is not consumed.
- Back-to-back timing, with start accepted at edge of cycle 0:
  - Elements accepted in cycles 1..len, one per cycle: parks serve the first two, returns serve the rest.
  - MERGE issues 3 cycles after the last accept.
  - out_valid rises 6 cycles after the last accept.
- Arithmetic: all FP16 math is delegated to the adder. This block never inspects or modifies FP16 fields.

Test Plan:
- len=4, elements 3C00,4000,4200,4400 back-to-back, out_ready=1 → partials 4400 (1+3) and 4600 (2+4), out_data=16'h4900 (10.0), out_valid rises 6 cycles after the 4th accept, pulses 1 cycle.
- len=2, elements 4000,C000 → out_data=16'h0000 (2.0 + −2.0 cancels).
- len=1, element 3C00 → out_data=16'h3C00; len=0 with start → DONE next cycle, out_data=16'h0000, in_ready never high.
- len=4 same data as first scenario, in_valid with 1–3 cycle random gaps → out_data=16'h4900; in_ready never high with both partials in flight and ret=0; no element dropped or duplicated (cnt=4).
- out_ready held low 5 cycles in DONE → out_valid and out_data=16'h4900 stable throughout; start pulsed during DONE ignored; busy=1 until handshake.
- rst asserted after the 2nd accept of a len=4 run → all outputs at reset values the same cycle; new start with len=2 {3C00,3C00} → out_data=16'h4000.

Source files
------------

// File: rtl/fp16_vec_accum.sv
// ============================================================================
// Module   : fp16_vec_accum
// Purpose  : FP16 vector-reduction controller driving an external 2-stage
//            pipelined FP16 adder using two interleaved partial sums.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fp16_vec_accum #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    input  logic [15:0]      in_data,
    output logic             in_ready,
    output logic [15:0]      add_a,
    output logic [15:0]      add_b,
    input  logic [15:0]      add_sum,
    output logic             out_valid,
    output logic [15:0]      out_data,
    input  logic             out_ready,
    output logic             busy
);

    localparam logic [LEN_W-1:0] c_one = {{(LEN_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_DRAIN = 3'd2,
        S_MERGE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [LEN_W-1:0] r_len_q, w_len_nxt;
    logic [LEN_W-1:0] r_cnt,   w_cnt_nxt;
    logic [15:0]      r_p0,    w_p0_nxt;
    logic [15:0]      r_p1,    w_p1_nxt;
    logic             r_p0_v,  w_p0_v_nxt;
    logic             r_p1_v,  w_p1_v_nxt;
    logic [1:0]       r_iss;
    logic             w_issue;
    logic [15:0]      r_out_data, w_out_nxt;
    logic             w_ret;
    logic             w_in_ready;
    logic [15:0]      w_add_a, w_add_b;

    // A returning partial is identified purely by issue history, so a reset
    // that clears r_iss makes any adder results still in flight harmless.
    assign w_ret = r_iss[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_len_q    <= '0;
            r_cnt      <= '0;
            r_p0       <= 16'h0000;
            r_p1       <= 16'h0000;
            r_p0_v     <= 1'b0;
            r_p1_v     <= 1'b0;
            r_iss      <= 2'b00;
            r_out_data <= 16'h0000;
        end else begin
            r_state    <= w_state_nxt;
            r_len_q    <= w_len_nxt;
            r_cnt      <= w_cnt_nxt;
            r_p0       <= w_p0_nxt;
            r_p1       <= w_p1_nxt;
            r_p0_v     <= w_p0_v_nxt;
            r_p1_v     <= w_p1_v_nxt;
            r_iss      <= {r_iss[0], w_issue};
            r_out_data <= w_out_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_len_nxt   = r_len_q;
        w_cnt_nxt   = r_cnt;
        w_p0_nxt    = r_p0;
        w_p1_nxt    = r_p1;
        w_p0_v_nxt  = r_p0_v;
        w_p1_v_nxt  = r_p1_v;
        w_out_nxt   = r_out_data;
        w_issue     = 1'b0;
        w_in_ready  = 1'b0;
        w_add_a     = 16'h0000;
        w_add_b     = 16'h0000;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_len_nxt   = len;
                    w_cnt_nxt   = '0;
                    w_p0_nxt    = 16'h0000;
                    w_p1_nxt    = 16'h0000;
                    w_p0_v_nxt  = 1'b1;
                    w_p1_v_nxt  = 1'b1;
                    w_out_nxt   = 16'h0000;
                    w_state_nxt = (len == '0) ? S_DONE : S_RUN;
                end
            end

            S_RUN: begin
                w_in_ready = (r_cnt < r_len_q) && (w_ret || r_p0_v || r_p1_v);
                if (in_valid && w_in_ready) begin
                    w_issue   = 1'b1;
                    w_add_b   = in_data;
                    w_cnt_nxt = r_cnt + c_one;
                    if (w_ret) begin
                        w_add_a = add_sum;
                    end else if (r_p0_v) begin
                        w_add_a    = r_p0;
                        w_p0_v_nxt = 1'b0;
                    end else begin
                        w_add_a    = r_p1;
                        w_p1_v_nxt = 1'b0;
                    end
                    if (w_cnt_nxt == r_len_q) begin
                        w_state_nxt = S_DRAIN;
                    end
                end else if (w_ret) begin
                    if (!r_p0_v) begin
                        w_p0_nxt   = add_sum;
                        w_p0_v_nxt = 1'b1;
                    end else begin
                        w_p1_nxt   = add_sum;
                        w_p1_v_nxt = 1'b1;
                    end
                end
            end

            S_DRAIN: begin
                if (w_ret) begin
                    if (!r_p0_v) begin
                        w_p0_nxt   = add_sum;
                        w_p0_v_nxt = 1'b1;
                    end else begin
                        w_p1_nxt   = add_sum;
                        w_p1_v_nxt = 1'b1;
                    end
                end
                // Look ahead so the merge issues the cycle after the last return parks.
                if (w_p0_v_nxt && w_p1_v_nxt && !r_iss[0]) begin
                    w_state_nxt = S_MERGE;
                end
            end

            S_MERGE: begin
                if (r_p0_v && r_p1_v) begin
                    w_issue    = 1'b1;
                    w_add_a    = r_p0;
                    w_add_b    = r_p1;
                    w_p0_v_nxt = 1'b0;
                    w_p1_v_nxt = 1'b0;
                end else if (w_ret) begin
                    w_out_nxt   = add_sum;
                    w_state_nxt = S_DONE;
                end
            end

            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign in_ready  = w_in_ready;
    assign add_a     = w_add_a;
    assign add_b     = w_add_b;
    assign out_valid = (r_state == S_DONE);
    assign out_data  = r_out_data;
    assign busy      = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_fp16_vec_accum.sv
// ============================================================================
// Module   : tb_fp16_vec_accum
// Purpose  : Self-checking bench for fp16_vec_accum with a 2-stage adder model.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fp16_vec_accum;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] len = 16'd0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = 16'h0000;
    logic        in_ready;
    logic [15:0] add_a, add_b, add_sum;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready = 1'b1;
    logic        busy;

    int          cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;
    logic [15:0] elems [0:15];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fp16_vec_accum #(.LEN_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_sum   (add_sum),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy)
    );

    // FP16 <-> real conversion; test values are small integers so all sums are exact.
    function automatic real h2r(input logic [15:0] h);
        real r;
        int  ex;
        r  = (h[14:10] == 5'd0) ? real'(h[9:0]) : real'(1024 + int'(h[9:0]));
        ex = (h[14:10] == 5'd0) ? -24 : int'(h[14:10]) - 25;
        for (int i = 0; i < 40 && ex > 0; i++) begin r = r * 2.0; ex--; end
        for (int i = 0; i < 40 && ex < 0; i++) begin r = r / 2.0; ex++; end
        return h[15] ? -r : r;
    endfunction

    function automatic logic [15:0] r2h(input real x);
        real a;
        int  ex, m;
        logic [15:0] h;
        if (x == 0.0) return 16'h0000;
        a  = (x < 0.0) ? -x : x;
        ex = 15;
        for (int i = 0; i < 40 && a >= 2.0; i++) begin a = a / 2.0; ex++; end
        for (int i = 0; i < 40 && a < 1.0; i++) begin a = a * 2.0; ex--; end
        m = int'((a - 1.0) * 1024.0);
        h = {(x < 0.0), ex[4:0], m[9:0]};
        return h;
    endfunction

    function automatic logic [15:0] fadd(input logic [15:0] a, input logic [15:0] b);
        if (a == 16'h0000) return b;
        if (b == 16'h0000) return a;
        return r2h(h2r(a) + h2r(b));
    endfunction

    // External adder: two register stages, shares rst with the DUT.
    logic [15:0] s1, s2;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 16'h0000;
            s2 <= 16'h0000;
        end else begin
            s1 <= fadd(add_a, add_b);
            s2 <= s1;
        end
    end
    assign add_sum = s2;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        else n_pass++;
    endtask

    task automatic run_case(input string nm, input int n, input int maxgap,
                            input int hold, input logic [15:0] exp);
        int s_cyc, acc, first_acc, last_acc, ir_err, hold_err, waitc, gap;
        logic [15:0] held;
        ir_err = 0; hold_err = 0;
        @(negedge clk);
        start = 1'b1; len = n[15:0]; out_ready = (hold == 0); s_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        acc = 0; first_acc = -1; last_acc = s_cyc; waitc = 0;
        while (acc < n && waitc < 300) begin
            if (acc > 0 && maxgap > 0) begin
                gap = $urandom_range(1, maxgap);
                for (int g = 0; g < gap; g++) begin
                    in_valid = 1'b0; in_data = 16'($urandom);
                    #1 if (in_ready !== 1'b1) ir_err++;
                    @(negedge clk); waitc++;
                end
            end
            in_valid = 1'b1; in_data = elems[acc];
            #1;
            if (in_ready !== 1'b1) ir_err++;
            else begin
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
                acc++;
            end
            @(negedge clk); waitc++;
        end
        in_valid = 1'b0; in_data = 16'h0000;
        chk({nm, " accepted"}, acc, n);
        if (maxgap == 0 && n > 0) chk({nm, " first_accept"}, first_acc - s_cyc, 1);
        #1; waitc = 0;
        while (out_valid !== 1'b1 && waitc < 60) begin
            if (in_ready !== 1'b0) ir_err++;
            @(negedge clk); #1; waitc++;
        end
        chk({nm, " latency"}, cyc - last_acc, (n == 0) ? 1 : 6);
        chk({nm, " result"}, out_data, exp);
        held = out_data;
        for (int k = 0; k < hold; k++) begin
            if (out_valid !== 1'b1 || out_data !== held || busy !== 1'b1 ||
                in_ready !== 1'b0 || add_a !== 16'h0 || add_b !== 16'h0) hold_err++;
            @(negedge clk);
            start = (k == 1); len = 16'd3;
            #1;
        end
        if (hold > 0) chk({nm, " hold_stable"}, hold_err, 0);
        start = 1'b0; out_ready = 1'b1;
        @(negedge clk); #1;
        chk({nm, " post_handshake"}, {out_valid, busy}, 2'b00);
        chk({nm, " in_ready_protocol"}, ir_err, 0);
    endtask

    typedef struct {
        int          n;
        logic [15:0] e [0:3];
        int          maxgap;
        int          hold;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl [0:5];

    initial begin
        int          sum, v, n;
        logic [15:0] exp_h;

        tbl[0] = '{4, '{16'h3C00, 16'h4000, 16'h4200, 16'h4400}, 0, 0, 16'h4900};
        tbl[1] = '{2, '{16'h4000, 16'hC000, 16'h0000, 16'h0000}, 0, 0, 16'h0000};
        tbl[2] = '{1, '{16'h3C00, 16'h0000, 16'h0000, 16'h0000}, 0, 0, 16'h3C00};
        tbl[3] = '{0, '{16'h0000, 16'h0000, 16'h0000, 16'h0000}, 0, 0, 16'h0000};
        tbl[4] = '{4, '{16'h3C00, 16'h4000, 16'h4200, 16'h4400}, 3, 0, 16'h4900};
        tbl[5] = '{4, '{16'h3C00, 16'h4000, 16'h4200, 16'h4400}, 0, 5, 16'h4900};

        // Reset state while rst is held.
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("reset out_valid", out_valid, 0);
        chk("reset out_data", out_data, 16'h0000);
        chk("reset in_ready_busy", {in_ready, busy}, 2'b00);
        chk("reset add_ops", {add_a, add_b}, 32'h0);
        @(negedge clk); rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 4; j++) elems[j] = tbl[i].e[j];
            run_case($sformatf("vec%0d", i), tbl[i].n, tbl[i].maxgap, tbl[i].hold, tbl[i].exp);
        end

        // Reset after the second accept of a len=4 run.
        for (int j = 0; j < 4; j++) elems[j] = tbl[0].e[j];
        @(negedge clk); start = 1'b1; len = 16'd4;
        @(negedge clk); start = 1'b0;
        in_valid = 1'b1; in_data = elems[0];
        @(negedge clk); in_data = elems[1];
        @(negedge clk); in_valid = 1'b0; rst = 1'b1;
        #1;
        chk("midrst outputs", {out_valid, in_ready, busy}, 3'b000);
        chk("midrst out_data", out_data, 16'h0000);
        chk("midrst add_ops", {add_a, add_b}, 32'h0);
        @(negedge clk); rst = 1'b0;
        elems[0] = 16'h3C00; elems[1] = 16'h3C00;
        run_case("after_rst", 2, 0, 0, 16'h4000);

        // Random lengths, values and gaps against an integer-sum reference.
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 12);
            sum = 0;
            for (int j = 0; j < n; j++) begin
                v = int'($urandom_range(0, 8)) - 4;
                sum += v;
                elems[j] = r2h(real'(v));
            end
            exp_h = r2h(real'(sum));
            run_case($sformatf("rand%0d", r), n, $urandom_range(0, 2), 0, exp_h);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
